mux_4to1_assertion: RTL and testbench

- 4-input, WIDTH-bit data multiplexer with four independent one-hot select lines.
- The data path is purely combinational.
- A clocked checker monitors the selects. It flags select-protocol violations through SVA assertions and a sticky error output.
- Used as a leaf datapath-steering block wherever a one-hot-selected 4:1 mux with built-in protocol checking is needed.

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux_sel_checker.sv | 67 ++++++
 rtl/mux_4to1_assertion.sv | 62 ++++++
 tb/tb_mux_4to1_assertion.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and types for the one-hot 4:1 mux
// and its select-protocol checker.
package mux_pkg;

  localparam int NUM_IN = 4;

  typedef logic [NUM_IN-1:0] sel_vec_t;

  localparam int SEL_A = 0;
  localparam int SEL_B = 1;
  localparam int SEL_C = 2;
  localparam int SEL_D = 3;

endpackage

// File: rtl/mux_sel_checker.sv
// Sticky select-protocol error flag plus optional SVA
// checks on the one-hot select vector and mux output.
module mux_sel_checker
  import mux_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit ASSERT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  sel_vec_t         sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [WIDTH-1:0] out,
  output logic             sel_err
);

  logic legal;

  // X/Z on any select leaves legal non-1, which also counts as illegal
  assign legal = $onehot(sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (legal !== 1'b1) begin
      sel_err <= 1'b1;
    end
  end

  if (ASSERT_EN) begin : g_sva

    a_onehot: assert property (
      @(posedge clk) disable iff (rst)
      $onehot(sel)
    ) else $error("a_onehot sel=%b out=%h", sel, out);

    a_no_x: assert property (
      @(posedge clk) disable iff (rst)
      !$isunknown(sel)
    ) else $error("a_no_x sel=%b out=%h", sel, out);

    a_out_match_a: assert property (
      @(posedge clk) disable iff (rst)
      sel[SEL_A] |-> out == in_a
    ) else $error("a_out_match_a sel=%b out=%h", sel, out);

    a_out_match_b: assert property (
      @(posedge clk) disable iff (rst)
      sel[SEL_B] |-> out == in_b
    ) else $error("a_out_match_b sel=%b out=%h", sel, out);

    a_out_match_c: assert property (
      @(posedge clk) disable iff (rst)
      sel[SEL_C] |-> out == in_c
    ) else $error("a_out_match_c sel=%b out=%h", sel, out);

    a_out_match_d: assert property (
      @(posedge clk) disable iff (rst)
      sel[SEL_D] |-> out == in_d
    ) else $error("a_out_match_d sel=%b out=%h", sel, out);

  end

endmodule

// File: rtl/mux_4to1_assertion.sv
// One-hot selected WIDTH-bit 4:1 mux, priority a>b>c>d,
// with a clocked select-protocol checker alongside.
module mux_4to1_assertion
  import mux_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit ASSERT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic             sel_a,
  input  logic             sel_b,
  input  logic             sel_c,
  input  logic             sel_d,
  output logic [WIDTH-1:0] out,
  output logic             sel_err
);

  sel_vec_t sel;

  always_comb begin
    sel        = '0;
    sel[SEL_A] = sel_a;
    sel[SEL_B] = sel_b;
    sel[SEL_C] = sel_c;
    sel[SEL_D] = sel_d;
  end

  // Priority chain keeps out defined even for illegal selects
  always_comb begin
    out = '0;
    if (sel[SEL_A]) begin
      out = in_a;
    end else if (sel[SEL_B]) begin
      out = in_b;
    end else if (sel[SEL_C]) begin
      out = in_c;
    end else if (sel[SEL_D]) begin
      out = in_d;
    end
  end

  mux_sel_checker #(
    .WIDTH     (WIDTH),
    .ASSERT_EN (ASSERT_EN)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_c    (in_c),
    .in_d    (in_d),
    .out     (out),
    .sel_err (sel_err)
  );

endmodule

// File: tb/tb_mux_4to1_assertion.sv
// Table-driven and randomized check of mux_4to1_assertion
// against a behavioural priority/one-hot model.
module tb_mux_4to1_assertion;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_a, in_b, in_c, in_d;
  logic         sel_a, sel_b, sel_c, sel_d;
  logic [W-1:0] out;
  logic         sel_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_err;

  always #5 clk = ~clk;

  // Illegal selects are exercised deliberately, so SVA stays off here
  mux_4to1_assertion #(
    .WIDTH     (W),
    .ASSERT_EN (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_c    (in_c),
    .in_d    (in_d),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .sel_c   (sel_c),
    .sel_d   (sel_d),
    .out     (out),
    .sel_err (sel_err)
  );

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] a, b, c, d;
    logic         r;
    logic [W-1:0] eout;
    logic         eerr;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [W-1:0] ref_out(
    input logic [3:0] s,
    input logic [W-1:0] a, b, c, d
  );
    logic [W-1:0] data[4];
    data = '{a, b, c, d};
    for (int i = 0; i < 4; i++)
      if (s[i]) return data[i];
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [W-1:0] d, input logic r);
    sel_a = s[0]; sel_b = s[1]; sel_c = s[2]; sel_d = s[3];
    in_a = a; in_b = b; in_c = c; in_d = d;
    rst = r;
  endtask

  // Sticky-error model: one update per posedge
  task automatic model_edge(input logic [3:0] s, input logic r);
    if (r) exp_err = 1'b0;
    else if ($countones(s) != 1) exp_err = 1'b1;
  endtask

  task automatic cycle(input logic [3:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [W-1:0] d, input logic r,
                       input string nm);
    logic [W-1:0] eo;
    @(negedge clk);
    drive(s, a, b, c, d, r);
    eo = ref_out(s, a, b, c, d);
    #1 chk({nm, "_out_now"}, 32'(out), 32'(eo));
    @(posedge clk);
    model_edge(s, r);
    @(negedge clk);
    chk({nm, "_out"}, 32'(out), 32'(eo));
    chk({nm, "_err"}, 32'(sel_err), 32'(exp_err));
  endtask

  initial begin
    drive(4'b0001, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    exp_err = 1'b0;

    tbl[0]  = '{4'b0001, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, 4'hA, 1'b0};
    tbl[1]  = '{4'b0001, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 4'hA, 1'b0};
    tbl[2]  = '{4'b0010, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 4'hB, 1'b0};
    tbl[3]  = '{4'b0100, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 4'hC, 1'b0};
    tbl[4]  = '{4'b1000, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 4'hD, 1'b0};
    tbl[5]  = '{4'b1000, 4'hA, 4'hB, 4'hC, 4'h5, 1'b0, 4'h5, 1'b0};
    tbl[6]  = '{4'b0000, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 4'h0, 1'b1};
    tbl[7]  = '{4'b0001, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 4'hA, 1'b1};
    tbl[8]  = '{4'b0010, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, 4'hB, 1'b0};
    tbl[9]  = '{4'b0010, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 4'hB, 1'b0};
    tbl[10] = '{4'b0101, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 4'hA, 1'b1};
    tbl[11] = '{4'b0100, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 4'hC, 1'b1};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d,
            tbl[i].r);
      #1 chk($sformatf("tbl%0d_out_now", i), 32'(out),
             32'(tbl[i].eout));
      @(negedge clk);
      chk($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].eout));
      chk($sformatf("tbl%0d_err", i), 32'(sel_err),
          32'(tbl[i].eerr));
    end
    exp_err = tbl[11].eerr;

    // Zero-latency data change with sel_d held, between clock edges
    @(negedge clk);
    drive(4'b1000, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    @(posedge clk);
    model_edge(4'b1000, 1'b1);
    #2 in_d = 4'h5;
    #1 chk("d_change_now", 32'(out), 32'h5);

    // Reset pulse while sel_b held: out must not glitch
    cycle(4'b0010, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, "pre_rst");
    cycle(4'b0010, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, "in_rst");
    cycle(4'b0010, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, "post_rst");

    // Reset while selects are illegal still clears the flag
    cycle(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, "all_on");
    cycle(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, "rst_illegal");
    cycle(4'b0100, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, "legal_after");

    for (int i = 0; i < 300; i++) begin
      logic [3:0] s;
      logic       r;
      if ($urandom_range(0, 3) != 0)
        s = 4'(1 << $urandom_range(0, 3));
      else
        s = 4'($urandom);
      r = ($urandom_range(0, 19) == 0);
      cycle(s, 4'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), r, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
